// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
//
// Time-multiplexed, active-low seven-segment display controller.
// A free-running prescaler selects one digit at a time. Each digit is lit
// for 2^DIVIDE_BY clk cycles. The displayed value, the decimal points and
// the leading-zero enable come from a shadow register. That register
// reloads only at the frame boundary, so a frame never mixes old and new
// digits.
//
// Optional feature macro: SEG7_BRIGHTNESS_EN
//   When defined, a 4-bit duty input is added. Within each digit slot, the
//   anode is enabled only while the top four prescaler bits are below the
//   shadowed duty value.
//
// Ports
//   clk          board clock, rising edge
//   reset_n      asynchronous active-low reset
//   value        packed hex nibbles; nibble i drives digit i (digit 0 rightmost)
//   dp_in        per-digit decimal point request, active-high
//   lz_en        leading-zero suppression enable (shadowed)
//   blank        global blank, sampled live
//   duty         brightness duty 0..15 (only with SEG7_BRIGHTNESS_EN)
//   an           anode enables, active-low, one-cold
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   frame_start  one-cycle pulse when the shadow register loads
// ---------------------------------------------------------------------------
module seg7_scan_display #(
    parameter int DIGITS    = 4,
    parameter int DIVIDE_BY = 17
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_en,
    input  logic                  blank,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]            duty,
`endif
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    // Hex to active-low segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [DIVIDE_BY-1:0] cnt_p0;
    logic [IDX_W-1:0]     idx_p0;
    logic [4*DIGITS-1:0]  sh_val;
    logic [DIGITS-1:0]    sh_dp;
    logic                 sh_lz;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]           sh_duty;
`endif

    logic                 tick;
    logic                 frame_tick;
    logic [3:0]           nib;
    logic                 dp_req;
    logic                 suppress;
    logic                 zero_run;
    logic                 lit;
    logic [DIGITS-1:0]    an_next;
    logic [6:0]           seg_next;
    logic                 dp_next;

    assign tick       = &cnt_p0;
    assign frame_tick = tick && (idx_p0 == LAST_IDX);

    // ---- scan stage: select the current digit and decide what it shows ----
    always_comb begin
        nib      = 4'h0;
        dp_req   = 1'b0;
        suppress = 1'b0;
        // zero_run holds "all nibbles from the top down to i are zero".
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (sh_val[4*i +: 4] == 4'h0);
            if (idx_p0 == IDX_W'(i)) begin
                nib      = sh_val[4*i +: 4];
                dp_req   = sh_dp[i];
                suppress = sh_lz && (i != 0) && zero_run;
            end
        end

`ifdef SEG7_BRIGHTNESS_EN
        lit = (cnt_p0[DIVIDE_BY-1 -: 4] < sh_duty);
`else
        lit = 1'b1;
`endif

        if (blank || suppress) begin
            an_next  = '1;
            seg_next = 7'h7F;
            dp_next  = 1'b1;
        end else begin
            // Only the anode is gated by brightness; seg/dp stay driven.
            an_next  = lit ? ~(DIGITS'(1) << idx_p0) : '1;
            seg_next = seg7_decode(nib);
            dp_next  = ~dp_req;
        end
    end

    // ---- state and output register stage ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_p0      <= '0;
            idx_p0      <= '0;
            sh_val      <= '0;
            sh_dp       <= '0;
            sh_lz       <= 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
            sh_duty     <= 4'h0;
`endif
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt_p0      <= cnt_p0 + 1'b1;
            frame_start <= frame_tick;

            if (tick) begin
                if (idx_p0 == LAST_IDX) begin
                    idx_p0 <= '0;
                end else begin
                    idx_p0 <= idx_p0 + 1'b1;
                end
            end

            // Inputs are captured only at the frame boundary to avoid tearing.
            if (frame_tick) begin
                sh_val  <= value;
                sh_dp   <= dp_in;
                sh_lz   <= lz_en;
`ifdef SEG7_BRIGHTNESS_EN
                sh_duty <= duty;
`endif
            end

            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule
